data_array_port_a_arbiter: RTL and testbench
============================================

// Module: data_array_port_a_arbiter
// PURPOSE
//  Owns port A of the SIMD data array; port B is not touched. Shares it among three requesters:
//  - refill (full-line write from memory)
//  - store (word-masked write from the SIMD core)
//  - load (line read)
//  Also runs a clear sequencer that zeroes every line after a flush. Sits between the cache
//  controller and the data array.
// PARAMETERS
//  DATA_WIDTH    256  line width in bits
//  INDEX_WIDTH   9    line index width; array depth is 2**INDEX_WIDTH
//  WORD_BITS     3    log2(words per line); mask width NW = 2**WORD_BITS
//  STARVE_LIMIT  4    max consecutive refill grants while store/load wait; range 1..15
// PORTS
//  clk              in   1            clock, rising edge
//  rst_n            in   1            asynchronous active-low reset
//  rf_valid         in   1            refill request
//  rf_ready         out  1            refill granted this cycle
//  rf_index         in   INDEX_WIDTH  refill line index
//  rf_data          in   DATA_WIDTH   refill line data
//  st_valid         in   1            store request
//  st_ready         out  1            store granted this cycle
//  st_index         in   INDEX_WIDTH  store line index
//  st_data          in   DATA_WIDTH   store data
//  st_mask          in   NW           per-word write enables
//  ld_valid         in   1            load request
//  ld_ready         out  1            load granted this cycle
//  ld_index         in   INDEX_WIDTH  load line index
//  ld_rsp_valid     out  1            load data valid; no backpressure
//  ld_rsp_data      out  DATA_WIDTH   load data
//  clr_start        in   1            pulse: start clear of all lines
//  clr_busy         out  1            clear in progress
//  clr_done         out  1            1-cycle pulse when clear finishes
//  arr_addr_a       out  INDEX_WIDTH  array port A address
//  arr_data_a       out  DATA_WIDTH   array port A write data
//  arr_we_a         out  1            array port A write enable
//  arr_valid_word_a out  NW           array port A word mask
//  arr_q_a          in   DATA_WIDTH   array port A read data; valid 1 cycle after address
// BEHAVIOUR
//  Reset values: all outputs 0; FSM=IDLE; rr_ptr=store; starve_cnt=0; clear index=0.
//  Handshake: a transfer occurs when valid && ready. Each ready is combinational from the valids
//    and state. At most one ready is high per cycle.
//  IDLE priority:
//    - refill first, unless starve_cnt==STARVE_LIMIT and (st_valid||ld_valid).
//    - otherwise store vs load by round robin: rr_ptr favours one; after a store/load grant,
//      rr_ptr points at the other.
//  starve_cnt:
//    - +1 on each refill grant while st_valid||ld_valid.
//    - cleared on a store/load grant or when neither waits.
//    - saturates at STARVE_LIMIT.
//  Port A drive, combinational from the grant:
//    - refill: we=1, mask all ones.
//    - store: we=|st_mask, mask=st_mask.
//    - load: we=0, mask=0, addr=ld_index.
//    - no grant: we=0; addr/data hold their last value.
//  Load latency:
//    - ld_rsp_valid is registered; high in cycle T+1 for a grant in cycle T.
//    - ld_rsp_data = arr_q_a, passed through combinationally in T+1.
//    - Back-to-back loads yield back-to-back responses.
//  FSM IDLE->CLEAR: clr_start sampled high in IDLE.
//    - Arbitration still happens in the clr_start cycle.
//    - clr_start in CLEAR is ignored.
//  CLEAR:
//    - All readies are 0; clr_busy=1.
//    - Each cycle writes zero with full mask to idx = 0, 1, ..., 2**INDEX_WIDTH-1.
//  FSM CLEAR->IDLE: after the write to the last index.
//    - clr_done=1 and clr_busy=0 in the first IDLE cycle.
//    - The index wraps to 0.
//  A load granted in the clr_start cycle still gets its response in the next cycle.
//  Asynchronous reset mid-clear: FSM=IDLE immediately, no clr_done, pending ld_rsp_valid dropped.
//  Requesters may change index/data while not granted; the arbiter does not hold their payloads.
// STRUCTURE
//  Package data_array_pkg:
//    - FSM state enum {IDLE, CLEAR}
//    - requester id enum {REQ_NONE, REQ_RF, REQ_ST, REQ_LD}
//    - default widths
//  Sub-module rr_arb2 (2-way round-robin: store/load) with its own rr_ptr.
//  FSM, starvation counter, clear counter and response register stay in this module.
// TESTING
//  1. Reset -> all outputs 0. Lone ld_valid idx 5, array line 5=0xAB.. -> ld_ready
//     same cycle; ld_rsp_valid and data 0xAB.. next cycle.
//  2. rf_valid, st_valid and ld_valid held high, STARVE_LIMIT=4 -> grants RF,RF,RF,RF,ST,RF,RF,RF,RF,LD.
//  3. st_valid and ld_valid only, held high -> grants alternate ST,LD,ST,LD. Store mask 8'h81
//     -> arr_valid_word_a=8'h81. Store mask 0 -> arr_we_a=0 but st_ready=1.
//  4. clr_start with INDEX_WIDTH=3 -> 8 writes, idx 0..7, data 0, mask 0xFF; readies 0 throughout;
//     clr_done in cycle 9; all loads afterwards return 0.
//  5. Assert rst_n=0 at clear idx 3 -> clr_busy 0 asynchronously; no clr_done. After release,
//     a new clr_start restarts at idx 0.
//  6. Load granted in the clr_start cycle -> its response appears in the first CLEAR cycle.
//     clr_start during CLEAR -> ignored; no extra writes.

Source files
------------

// File: rtl/data_array_port_a_arbiter_pkg.sv
// Shared types and default widths for the SIMD data array port A arbiter.
package data_array_pkg;

  localparam int unsigned DATA_WIDTH_DEF   = 256;
  localparam int unsigned INDEX_WIDTH_DEF  = 9;
  localparam int unsigned WORD_BITS_DEF    = 3;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned STARVE_W         = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_RF   = 2'd1,
    REQ_ST   = 2'd2,
    REQ_LD   = 2'd3
  } req_e;

endpackage

// File: rtl/data_array_port_a_arbiter_rr_arb2.sv
// Two-way round-robin between store and load; the pointer flips to the other side after a grant.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req_st_i,
  input  logic req_ld_i,
  output logic gnt_st_c_o,
  output logic gnt_ld_c_o
);

  // 0 = store favoured, 1 = load favoured
  logic ptr_ld_q, ptr_ld_d;

  always_comb begin
    gnt_st_c_o = 1'b0;
    gnt_ld_c_o = 1'b0;
    ptr_ld_d   = ptr_ld_q;
    if (en_i) begin
      if (req_st_i && (!ptr_ld_q || !req_ld_i)) begin
        gnt_st_c_o = 1'b1;
      end else if (req_ld_i) begin
        gnt_ld_c_o = 1'b1;
      end
    end
    if (gnt_st_c_o) begin
      ptr_ld_d = 1'b1;
    end else if (gnt_ld_c_o) begin
      ptr_ld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_ld_q <= 1'b0;
    end else begin
      ptr_ld_q <= ptr_ld_d;
    end
  end

endmodule

// File: rtl/data_array_port_a_arbiter.sv
// Port A owner of the SIMD data array: arbitrates refill/store/load and sequences
// a full-array zero clear after a flush.
module data_array_port_a_arbiter
  import data_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned INDEX_WIDTH  = INDEX_WIDTH_DEF,
  parameter int unsigned WORD_BITS    = WORD_BITS_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rf_valid,
  output logic                        rf_ready,
  input  logic [INDEX_WIDTH-1:0]      rf_index,
  input  logic [DATA_WIDTH-1:0]       rf_data,
  input  logic                        st_valid,
  output logic                        st_ready,
  input  logic [INDEX_WIDTH-1:0]      st_index,
  input  logic [DATA_WIDTH-1:0]       st_data,
  input  logic [(1<<WORD_BITS)-1:0]   st_mask,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [INDEX_WIDTH-1:0]      ld_index,
  output logic                        ld_rsp_valid,
  output logic [DATA_WIDTH-1:0]       ld_rsp_data,
  input  logic                        clr_start,
  output logic                        clr_busy,
  output logic                        clr_done,
  output logic [INDEX_WIDTH-1:0]      arr_addr_a,
  output logic [DATA_WIDTH-1:0]       arr_data_a,
  output logic                        arr_we_a,
  output logic [(1<<WORD_BITS)-1:0]   arr_valid_word_a,
  input  logic [DATA_WIDTH-1:0]       arr_q_a
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [STARVE_W-1:0]    LIMIT    = STARVE_W'(STARVE_LIMIT);

  state_e                  state_q, state_d;
  logic [STARVE_W-1:0]     starve_q, starve_d;
  logic [INDEX_WIDTH-1:0]  clr_idx_q, clr_idx_d;
  logic [INDEX_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    rsp_q, rsp_d;
  logic                    done_q, done_d;

  req_e grant;
  logic waiting, starve_block, rf_win, rr_en, gnt_st, gnt_ld;

  // Refill wins unless store/load have waited out the starvation budget
  assign waiting      = st_valid | ld_valid;
  assign starve_block = (starve_q == LIMIT) && waiting;
  assign rf_win       = rf_valid && !starve_block;
  assign rr_en        = (state_q == IDLE) && !rf_win;

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (rr_en),
    .req_st_i   (st_valid),
    .req_ld_i   (ld_valid),
    .gnt_st_c_o (gnt_st),
    .gnt_ld_c_o (gnt_ld)
  );

  always_comb begin
    grant = REQ_NONE;
    if (state_q == IDLE) begin
      if (rf_win) begin
        grant = REQ_RF;
      end else if (gnt_st) begin
        grant = REQ_ST;
      end else if (gnt_ld) begin
        grant = REQ_LD;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    starve_d         = starve_q;
    clr_idx_d        = clr_idx_q;
    addr_d           = addr_q;
    data_d           = data_q;
    done_d           = 1'b0;
    rsp_d            = (grant == REQ_LD);
    rf_ready         = (grant == REQ_RF);
    st_ready         = (grant == REQ_ST);
    ld_ready         = (grant == REQ_LD);
    arr_we_a         = 1'b0;
    arr_valid_word_a = '0;

    case (grant)
      REQ_RF: begin
        addr_d           = rf_index;
        data_d           = rf_data;
        arr_we_a         = 1'b1;
        arr_valid_word_a = '1;
      end
      REQ_ST: begin
        addr_d           = st_index;
        data_d           = st_data;
        arr_we_a         = |st_mask;
        arr_valid_word_a = st_mask;
      end
      REQ_LD: begin
        addr_d = ld_index;
      end
      default: ;
    endcase

    if ((grant == REQ_RF) && waiting) begin
      starve_d = (starve_q == LIMIT) ? starve_q : starve_q + STARVE_W'(1);
    end else if ((grant == REQ_ST) || (grant == REQ_LD) || !waiting) begin
      starve_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        addr_d           = clr_idx_q;
        data_d           = '0;
        arr_we_a         = 1'b1;
        arr_valid_word_a = '1;
        clr_idx_d        = clr_idx_q + INDEX_WIDTH'(1);
        if (clr_idx_q == LAST_IDX) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address/data follow the live grant and otherwise hold the last driven value
  assign arr_addr_a   = addr_d;
  assign arr_data_a   = data_d;
  assign clr_busy     = (state_q == CLEAR);
  assign clr_done     = done_q;
  assign ld_rsp_valid = rsp_q;
  assign ld_rsp_data  = rsp_q ? arr_q_a : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      clr_idx_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rsp_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      clr_idx_q <= clr_idx_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rsp_q     <= rsp_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_data_array_port_a_arbiter.sv
// Directed bench for the port A arbiter with a behavioural data array and a load-response scoreboard.
module tb_data_array_port_a_arbiter;

  localparam int unsigned DW = 256;
  localparam int unsigned IW = 3;
  localparam int unsigned WB = 3;
  localparam int unsigned NW = 8;
  localparam int unsigned WWORD = DW / NW;
  localparam int unsigned SL = 4;

  localparam logic [2:0] G_NO = 3'b000;
  localparam logic [2:0] G_RF = 3'b100;
  localparam logic [2:0] G_ST = 3'b010;
  localparam logic [2:0] G_LD = 3'b001;
  localparam logic [2:0] SEQ2 [10] = '{G_RF, G_RF, G_RF, G_RF, G_ST, G_RF, G_RF, G_RF, G_RF, G_LD};
  localparam logic [2:0] SEQ3 [4]  = '{G_ST, G_LD, G_ST, G_LD};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rf_valid, rf_ready, st_valid, st_ready, ld_valid, ld_ready;
  logic [IW-1:0] rf_index, st_index, ld_index, arr_addr_a;
  logic [DW-1:0] rf_data, st_data, ld_rsp_data, arr_data_a, arr_q_a;
  logic [NW-1:0] st_mask, arr_valid_word_a;
  logic          ld_rsp_valid, clr_start, clr_busy, clr_done, arr_we_a;

  logic [DW-1:0] mem [0:(1<<IW)-1];
  logic [DW-1:0] sb [$];
  logic [DW-1:0] pat;
  int n_checks = 0;
  int n_fail   = 0;

  data_array_port_a_arbiter #(
    .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .WORD_BITS(WB), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_index(rf_index), .rf_data(rf_data),
    .st_valid(st_valid), .st_ready(st_ready), .st_index(st_index), .st_data(st_data),
    .st_mask(st_mask),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_index(ld_index),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .arr_addr_a(arr_addr_a), .arr_data_a(arr_data_a), .arr_we_a(arr_we_a),
    .arr_valid_word_a(arr_valid_word_a), .arr_q_a(arr_q_a)
  );

  always #5 clk = ~clk;

  // Data array: word-masked write, registered read one cycle after the address
  always @(posedge clk) begin
    if (arr_we_a) begin
      for (int w = 0; w < NW; w++) begin
        if (arr_valid_word_a[w]) mem[arr_addr_a][w*WWORD +: WWORD] <= arr_data_a[w*WWORD +: WWORD];
      end
    end
    arr_q_a <= mem[arr_addr_a];
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [2:0] gnt_vec();
    return {rf_ready, st_ready, ld_ready};
  endfunction

  always @(negedge clk) begin
    if (ld_rsp_valid === 1'b1) begin
      if (sb.size() == 0) chk("ld_rsp_expected", DW'(sb.size() != 0), DW'(1));
      else chk("ld_rsp_data", ld_rsp_data, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pat = {32{8'hAB}};
    rst_n = 1'b0;
    rf_valid = 1'b0; st_valid = 1'b0; ld_valid = 1'b0; clr_start = 1'b0;
    rf_index = '0; st_index = '0; ld_index = '0;
    rf_data = '0; st_data = '0; st_mask = '0;
    repeat (2) step();

    // Reset state
    mid();
    chk("rst_readies", DW'(gnt_vec()), DW'(G_NO));
    chk("rst_rsp_valid", DW'(ld_rsp_valid), 0);
    chk("rst_rsp_data", ld_rsp_data, 0);
    chk("rst_clr", DW'({clr_busy, clr_done}), 0);
    chk("rst_addr", DW'(arr_addr_a), 0);
    chk("rst_data", arr_data_a, 0);
    chk("rst_we_mask", DW'({arr_we_a, arr_valid_word_a}), 0);
    rst_n = 1'b1;
    step();

    // Lone refill writes line 5, then a lone load reads it back
    rf_valid = 1'b1; rf_index = 3'd5; rf_data = pat;
    mid();
    chk("rf_grant", DW'(gnt_vec()), DW'(G_RF));
    chk("rf_we_mask", DW'({arr_we_a, arr_valid_word_a}), DW'(9'h1FF));
    chk("rf_addr", DW'(arr_addr_a), DW'(5));
    chk("rf_data", arr_data_a, pat);
    step();
    rf_valid = 1'b0;
    ld_valid = 1'b1; ld_index = 3'd5;
    sb.push_back(pat);
    mid();
    chk("ld_grant", DW'(gnt_vec()), DW'(G_LD));
    chk("ld_we_mask", DW'({arr_we_a, arr_valid_word_a}), 0);
    chk("ld_addr", DW'(arr_addr_a), DW'(5));
    step();
    ld_valid = 1'b0;
    mid();
    chk("ld_rsp_next_cycle", DW'(ld_rsp_valid), 1);
    chk("idle_hold_addr", DW'({arr_we_a, arr_addr_a}), DW'(5));
    step();

    // All three requesters: starvation limit forces store/load in round robin
    rf_valid = 1'b1; rf_index = 3'd1; rf_data = ~pat;
    st_valid = 1'b1; st_index = 3'd2; st_data = {8{32'h1234_5678}}; st_mask = 8'hFF;
    ld_valid = 1'b1; ld_index = 3'd5;
    for (int i = 0; i < 10; i++) begin
      mid();
      chk($sformatf("starve_grant_%0d", i), DW'(gnt_vec()), DW'(SEQ2[i]));
      if (SEQ2[i] == G_LD) sb.push_back(pat);
      step();
    end

    // Store and load only: strict alternation, mask pass-through, empty-mask store
    rf_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st_mask = (i == 0) ? 8'h81 : 8'h00;
      mid();
      chk($sformatf("rr_grant_%0d", i), DW'(gnt_vec()), DW'(SEQ3[i]));
      if (i == 0) chk("st_mask_81", DW'({arr_we_a, arr_valid_word_a}), DW'(9'h181));
      if (i == 2) chk("st_mask_0_we", DW'({st_ready, arr_we_a}), DW'(2'b10));
      if (SEQ3[i] == G_LD) sb.push_back(pat);
      step();
    end
    st_valid = 1'b0; ld_valid = 1'b0;
    mid();
    step();

    // Clear with a load granted in the start cycle; requests held during clear
    clr_start = 1'b1; ld_valid = 1'b1; ld_index = 3'd5;
    sb.push_back(pat);
    mid();
    chk("clr_start_ld_grant", DW'(gnt_vec()), DW'(G_LD));
    chk("clr_start_busy", DW'(clr_busy), 0);
    step();
    rf_valid = 1'b1; st_valid = 1'b1; st_mask = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      clr_start = (k == 3);
      mid();
      chk($sformatf("clr_readies_%0d", k), DW'({gnt_vec(), clr_busy, clr_done}), DW'(5'b00010));
      chk($sformatf("clr_write_%0d", k), DW'({arr_we_a, arr_valid_word_a, arr_addr_a}), DW'({1'b1, 8'hFF, 3'(k)}));
      chk($sformatf("clr_data_%0d", k), arr_data_a, 0);
      if (k == 0) chk("clr_first_rsp", DW'(ld_rsp_valid), 1);
      step();
    end
    clr_start = 1'b0; rf_valid = 1'b0; st_valid = 1'b0; ld_valid = 1'b0;
    mid();
    chk("clr_done_pulse", DW'({clr_busy, clr_done, arr_we_a}), DW'(3'b010));
    step();
    mid();
    chk("clr_no_extra", DW'({clr_busy, clr_done, arr_we_a}), 0);
    step();

    // Back-to-back loads of every line return zero
    ld_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ld_index = 3'(i);
      sb.push_back('0);
      mid();
      chk($sformatf("post_clr_ld_%0d", i), DW'(gnt_vec()), DW'(G_LD));
      step();
    end
    ld_valid = 1'b0;
    mid();
    step();

    // Reset in the middle of a clear, then restart from index 0
    clr_start = 1'b1;
    mid();
    step();
    clr_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk($sformatf("clr2_addr_%0d", k), DW'(arr_addr_a), DW'(k));
      if (k < 3) step();
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_clr_busy", DW'({clr_busy, clr_done, arr_we_a}), 0);
    repeat (2) step();
    mid();
    rst_n = 1'b1;
    step();
    mid();
    chk("rst_mid_no_done", DW'({clr_busy, clr_done}), 0);
    step();
    clr_start = 1'b1;
    mid();
    step();
    clr_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mid();
      chk($sformatf("clr3_addr_%0d", k), DW'({clr_busy, arr_we_a, arr_addr_a}), DW'({2'b11, 3'(k)}));
      step();
    end
    mid();
    chk("clr3_done", DW'({clr_busy, clr_done}), DW'(2'b01));
    step();

    mid();
    chk("sb_empty", DW'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
